mem_block_image_pingpong: RTL

MEM_BLOCK_IMAGE_PINGPONG -- requirements
Module: mem_block_image_pingpong

---
 rtl/mem_block_image_pingpong.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_block_image_pingpong.sv
// Ping-pong image buffer: LANES complex-sample RAMs split into two halves, with a
// writer filling one half while a reader drains the other; two-cycle read latency.
module mem_block_image_pingpong #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    wr_en,
  input  logic [ADDR_WIDTH-1:0]                   wr_addr,
  input  logic [ROWS*COLS*2*DATA_WIDTH-1:0]       wr_data,
  input  logic [ROWS*COLS-1:0]                    wr_mask,
  input  logic                                    wr_done,
  output logic                                    wr_ready,
  input  logic                                    rd_en,
  input  logic [ADDR_WIDTH-1:0]                   rd_addr,
  input  logic                                    rd_done,
  output logic                                    rd_ready,
  output logic [ROWS*COLS*2*DATA_WIDTH-1:0]       rd_data,
  output logic                                    rd_valid,
  output logic                                    err
);

  localparam int LANES = ROWS * COLS;
  localparam int LW    = 2 * DATA_WIDTH;
  localparam int DEPTH = 1 << (ADDR_WIDTH + 1);

  logic                wr_sel;
  logic                rd_sel;
  logic [1:0]          full_cnt;
  logic [1:0]          full_cnt_next;
  logic                wr_acc;
  logic                wr_done_acc;
  logic                rd_acc;
  logic                rd_done_acc;
  logic                proto_err;
  logic                rd_pipe;
  logic [ADDR_WIDTH:0] wr_phys;
  logic [ADDR_WIDTH:0] rd_phys;
  logic [LW-1:0]       ram_q [LANES];
  logic [LANES*LW-1:0] ram_q_flat;

  assign wr_ready    = (full_cnt < 2'd2);
  assign rd_ready    = (full_cnt > 2'd0);
  assign wr_acc      = wr_en   & wr_ready;
  assign wr_done_acc = wr_done & wr_ready;
  assign rd_acc      = rd_en   & rd_ready;
  assign rd_done_acc = rd_done & rd_ready;
  assign wr_phys     = {wr_sel, wr_addr};
  assign rd_phys     = {rd_sel, rd_addr};

  // Any strobe arriving while its side is not ready is a protocol violation.
  assign proto_err = ((wr_en | wr_done) & ~wr_ready) |
                     ((rd_en | rd_done) & ~rd_ready);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    full_cnt_next = full_cnt;
    unique case ({wr_done_acc, rd_done_acc})
      2'b10:   full_cnt_next = full_cnt + 2'd1;
      2'b01:   full_cnt_next = full_cnt - 2'd1;
      default: full_cnt_next = full_cnt;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      full_cnt <= 2'd0;
      err      <= 1'b0;
    end else begin
      if (wr_done_acc) wr_sel <= ~wr_sel;
      if (rd_done_acc) rd_sel <= ~rd_sel;
      full_cnt <= full_cnt_next;
      if (proto_err) err <= 1'b1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [LW-1:0] mem [DEPTH];

    // NOTE: RAM arrays and their read register are deliberately not reset;
    // rd_valid gating makes their power-up contents irrelevant.
    always_ff @(posedge clk) begin
      if (wr_acc && wr_mask[k]) mem[wr_phys] <= wr_data[k*LW +: LW];
      if (rd_acc)               ram_q[k]     <= mem[rd_phys];
    end
  end

  always_comb begin
    ram_q_flat = '0;
    for (int k = 0; k < LANES; k++) ram_q_flat[k*LW +: LW] = ram_q[k];
  end

  // Output register; rd_pipe marks a RAM read whose data lands in ram_q this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pipe  <= rd_acc;
      rd_valid <= rd_pipe;
      if (rd_pipe) rd_data <= ram_q_flat;
    end
  end

endmodule
